// File: rtl/display_scan.sv
// Time-multiplexed 7-seg scan: one 4-bit code bus, active-low digit enables, dark gap before each slot.
// All outputs registered (1-cycle latency), no backpressure on load; DIM_EN adds a per-slot duty input.
module display_scan #(
  parameter int NDIG = 4,
  parameter int DIV  = 4,
  parameter int GAP  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_ready,
  input  logic [4*NDIG-1:0] i_notas,
`ifdef DIM_EN
  input  logic [4:0]        i_duty,
`endif
  output logic              o_a,
  output logic              o_b,
  output logic              o_c,
  output logic              o_d,
  output logic [NDIG-1:0]   o_an,
  output logic              o_ack,
  output logic              o_frame
);

  localparam int CW_DIV = $clog2(DIV + 1);
  localparam int CW_GAP = $clog2(GAP + 1);
  localparam int CW     = (CW_DIV > CW_GAP) ? CW_DIV : CW_GAP;
  localparam int IW     = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_GAP,
    S_ON
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [4*NDIG-1:0]   r_active;
  logic [4*NDIG-1:0]   r_shadow;
  logic                r_pending;
  logic [NDIG-1:0]     r_an;
  logic [3:0]          r_code;
  logic                r_ack;
  logic                r_frame;

  state_t              w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_frame_nxt;
  logic                w_xfer;
  logic [4*NDIG-1:0]   w_active_nxt;
  logic [4*NDIG-1:0]   w_shadow_nxt;
  logic                w_pending_nxt;
  logic [3:0]          w_code_nxt;
  logic [NDIG-1:0]     w_an_nxt;
  logic                w_lit;

`ifdef DIM_EN
  logic [CW-1:0]       r_lim;
  logic [CW-1:0]       w_lim_nxt;
  logic [4:0]          w_duty_c;
  int                  w_lim_calc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_OFF;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_GAP;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_frame_nxt = 1'b1;
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_cnt == DIV_LAST) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_frame_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // New frames only swap in at a frame start, or immediately while the display is off.
  always_comb begin
    w_xfer        = r_pending && (w_frame_nxt || (r_state == S_OFF));
    w_active_nxt  = w_xfer ? r_shadow : r_active;
    w_shadow_nxt  = i_ready ? i_notas : r_shadow;
    w_pending_nxt = i_ready ? 1'b1 : (w_xfer ? 1'b0 : r_pending);
    w_code_nxt    = '0;
    if (w_state_nxt != S_OFF) begin
      w_code_nxt = w_active_nxt[4*w_idx_nxt +: 4];
    end
  end

`ifdef DIM_EN
  always_comb begin
    w_duty_c   = (i_duty > 5'd16) ? 5'd16 : i_duty;
    w_lim_calc = (DIV * int'(w_duty_c)) >> 4;
    w_lim_nxt  = r_lim;
    if ((r_state == S_GAP) && (w_state_nxt == S_ON)) begin
      w_lim_nxt = CW'(w_lim_calc);
    end
    w_lit = (w_state_nxt == S_ON) && (w_cnt_nxt < w_lim_nxt);
  end
`else
  always_comb begin
    w_lit = (w_state_nxt == S_ON);
  end
`endif

  always_comb begin
    w_an_nxt = '1;
    if (w_lit) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_OFF;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_an      <= '1;
      r_code    <= '0;
      r_ack     <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_an      <= w_an_nxt;
      r_code    <= w_code_nxt;
      r_ack     <= w_xfer;
      r_frame   <= w_frame_nxt;
    end
  end

`ifdef DIM_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lim <= '0;
    end else begin
      r_lim <= w_lim_nxt;
    end
  end
`endif

  assign o_a     = r_code[3];
  assign o_b     = r_code[2];
  assign o_c     = r_code[1];
  assign o_d     = r_code[0];
  assign o_an    = r_an;
  assign o_ack   = r_ack;
  assign o_frame = r_frame;

endmodule
